fp_convert_seq: RTL
===================

// Module: fp_convert_seq
// PURPOSE
//   Multi-cycle sequencer for the 12-bit two's-complement -> 8-bit float conversion (S | E[2:0] | F[3:0]).
//   Accepts a sample over a valid/ready handshake, then runs sign-magnitude, iterative normalisation (1 shift/cycle), round and output.
//   Sits between the sample source and the display/consumer stage; one conversion in flight at a time.
// PARAMETERS
//   FAST_NORM   0   1 = normalise in one cycle via priority encode (NORM always exits after 1 cycle); 0 = iterative shift
//   CNT_W       8   width of completed-conversion counter conv_cnt
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous reset, active low; clears all state
//   in_valid   in   1      in_data valid
//   in_ready   out  1      block can accept; high only in IDLE
//   in_data    in   12     two's-complement sample D
//   out_valid  out  1      out_data valid; held until out_ready
//   out_ready  in   1      consumer accepts out_data
//   out_data   out  8      {S, E[2:0], F[3:0]}; value = (-1)^S * F * 2^E
//   busy       out  1      state != IDLE
//   conv_cnt   out  CNT_W  completed conversions (out handshakes), wraps mod 2^CNT_W
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, in_ready=1 once state decodes, out_valid=0, out_data=0, busy=0, conv_cnt=0, M=0, E=0.
//   States: IDLE -> SIGNMAG -> NORM -> ROUND -> DONE -> IDLE.
//   IDLE: in_ready=1; on in_valid at edge latch D, go SIGNMAG. No accept in any other state.
//   SIGNMAG: S=D[11]; M=|D| (12b, M[11]=0); D=0x800 saturates to M=0x7FF; E=7; go NORM.
//   NORM (FAST_NORM=0): each cycle: if M[10]=1 or E=0 -> ROUND; else M<=M<<1, E<=E-1.
//     n = shifts = min(lz-1, 7), lz = leading zeros of 12-bit M. Example: lz=1 -> E=7, n=0; lz>=8 -> E=0, n=7.
//   NORM (FAST_NORM=1): E and shifted M computed in one cycle; same final M/E as iterative path; go ROUND.
//   ROUND: F=M[10:7], fifth=M[6]. If fifth=1: F=F+1 (5-bit); if F=16 -> F=8, E=E+1; if E would be 8 -> E=7, F=15 (saturate).
//     Rounding is round-half-up on magnitude; sign applied after, so negatives round away from zero.
//   DONE: out_valid=1, out_data stable; on out_ready at edge: out_valid<=0, conv_cnt+1, -> IDLE.
//   Latency (FAST_NORM=0): out_valid high n+3 edges after accept edge; min 3 (n=0), max 10 (n=7).
//   Latency (FAST_NORM=1): always 3 edges.
//   Back-to-back: next accept no earlier than cycle after out handshake (in_ready rises in IDLE).
//   out_ready while not DONE: ignored. in_valid while busy: ignored, in_data not sampled.
//   conv_cnt wraps 2^CNT_W-1 -> 0 without side effect.
//   Reset mid-conversion: in-flight sample discarded, no output, counter cleared.
//   Zero input: M=0 never gets M[10]=1; exits on E=0 after 7 shifts -> out_data=0x00.
// TESTING
//   D=0x1A6 (422), out_ready=1 -> out_data=0x5D (13*2^5), out_valid 5 edges after accept, conv_cnt=1.
//   D=0x0FC (252) -> F rounds 15->16 renormalise -> out_data=0x58 (8*2^5); D=0xE5A (-422) -> 0xDD.
//   D=0x7FF -> exponent overflow saturate -> 0x7F; D=0x800 -> 0xFF; D=0x000 -> 0x00 after 10 edges.
//   D=0x00C -> E=0, F=12 -> 0x0C; out_ready held low 5 cycles -> out_valid/out_data stable, in_ready=0, in_valid pulses ignored.
//   Assert rst_n low mid-NORM -> immediately out_valid=0, busy=0, conv_cnt=0; next sample converts correctly.
//   FAST_NORM=1 random sweep of all 4096 D vs reference model -> identical out_data, latency always 3; CNT_W=2 wraps after 4.

Source files
------------

// File: rtl/fp_convert_seq.sv
// rtl/fp_convert_seq.sv - 12-bit two's-complement to 8-bit {S,E[2:0],F[3:0]} float conversion sequencer
module fp_convert_seq #(
    parameter int FAST_NORM = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             busy,
    output logic [CNT_W-1:0] conv_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SIGNMAG,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [11:0]       d_q, d_d;
    logic [11:0]       m_q, m_d;
    logic [2:0]        e_q, e_d;
    logic              s_q, s_d;
    logic [7:0]        out_data_q, out_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [11:0]       abs_d;
    logic [2:0]        fast_n;
    logic [4:0]        f_round;

    // -0x800 has no positive 12-bit counterpart, so it saturates to the largest magnitude
    always_comb begin
        abs_d = d_q[11] ? 12'(-d_q) : d_q;
        if (d_q == 12'h800) begin
            abs_d = 12'h7FF;
        end
    end

    // Shift count that brings the leading one to bit 10, capped at 7 (zero also lands on 7)
    always_comb begin
        fast_n = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (m_q[10-i]) begin
                fast_n = 3'(i);
            end
        end
    end

    assign f_round = {1'b0, m_q[10:7]} + {4'b0000, m_q[6]};

    always_comb begin
        state_d    = state_q;
        d_d        = d_q;
        m_d        = m_q;
        e_d        = e_q;
        s_d        = s_q;
        out_data_d = out_data_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    d_d     = in_data;
                    state_d = S_SIGNMAG;
                end
            end
            S_SIGNMAG: begin
                s_d     = d_q[11];
                m_d     = abs_d;
                e_d     = 3'd7;
                state_d = S_NORM;
            end
            S_NORM: begin
                if (FAST_NORM != 0) begin
                    m_d     = m_q << fast_n;
                    e_d     = e_q - fast_n;
                    state_d = S_ROUND;
                end else if (m_q[10] || (e_q == 3'd0)) begin
                    state_d = S_ROUND;
                end else begin
                    m_d = m_q << 1;
                    e_d = e_q - 3'd1;
                end
            end
            S_ROUND: begin
                // Carry out of the mantissa renormalises to 8, or saturates at the top exponent
                if (f_round[4]) begin
                    if (e_q == 3'd7) begin
                        out_data_d = {s_q, 3'd7, 4'hF};
                    end else begin
                        e_d        = e_q + 3'd1;
                        out_data_d = {s_q, e_q + 3'd1, 4'h8};
                    end
                end else begin
                    out_data_d = {s_q, e_q, f_round[3:0]};
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            d_q        <= '0;
            m_q        <= '0;
            e_q        <= '0;
            s_q        <= 1'b0;
            out_data_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            d_q        <= d_d;
            m_q        <= m_d;
            e_q        <= e_d;
            s_q        <= s_d;
            out_data_q <= out_data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = out_data_q;
    assign conv_cnt  = cnt_q;

endmodule
